// File: rtl/udcount_pkg.sv
// Shared constants and helpers for the cascaded up/down modulo counter.
// Optional saturating mode is enabled with the UDCOUNT_SAT_EN macro.
package udcount_pkg;

   localparam logic UD_UP   = 1'b0;
   localparam logic UD_DOWN = 1'b1;

   localparam int UDCOUNT_MAX_DIGITS = 8;

   function automatic logic [31:0] digit_clamp(
      input logic [31:0] value,
      input logic [31:0] radix
   );
      return (value >= radix) ? radix - 32'd1 : value;
   endfunction

endpackage

// File: rtl/udcount_digit.sv
// One modulo-RADIX up/down digit with parallel load and terminal detect.
// at_term flags the value from which the next step in direction ud rolls over.
module udcount_digit
   import udcount_pkg::*;
#(
   parameter int RADIX = 10,
   parameter int DW    = 4
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          step_in,
   input  logic          ud,
   input  logic          load,
   input  logic [DW-1:0] load_digit,
   output logic [DW-1:0] digit,
   output logic          at_term
);

   localparam logic [DW-1:0] TOP = DW'(RADIX - 1);

   logic [DW-1:0] digit_q;
   logic [DW-1:0] digit_d;

   always_comb begin
      digit_d = digit_q;
      if (load) begin
         digit_d = DW'(digit_clamp(32'(load_digit), 32'(RADIX)));
      end else if (step_in) begin
         if (ud == UD_UP) begin
            digit_d = (digit_q == TOP) ? '0 : digit_q + DW'(1);
         end else begin
            digit_d = (digit_q == '0) ? TOP : digit_q - DW'(1);
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         digit_q <= '0;
      end else begin
         digit_q <= digit_d;
      end
   end

   assign digit   = digit_q;
   assign at_term = (ud == UD_DOWN) ? (digit_q == '0) : (digit_q == TOP);

endmodule

// File: rtl/udcount_mod.sv
// Cascaded DIGITS x modulo-RADIX up/down counter with load, zero flag, wrap pulse.
// Define UDCOUNT_SAT_EN to saturate at the bounds instead of wrapping.
module udcount_mod
   import udcount_pkg::*;
#(
   parameter int DIGITS = 2,
   parameter int RADIX  = 10,
   parameter int DW     = 4
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 enable,
   input  logic                 ud,
   input  logic                 load,
   input  logic [DIGITS*DW-1:0] load_value,
   output logic [DIGITS*DW-1:0] q,
   output logic                 carry,
   output logic                 zero
);

   if (RADIX > 2**DW || RADIX < 2 || DIGITS < 1 || DIGITS > UDCOUNT_MAX_DIGITS) begin : g_bad_cfg
      $error("udcount_mod: illegal DIGITS/RADIX/DW combination");
   end

   logic [DIGITS-1:0] at_term;
   logic [DIGITS-1:0] step;
   logic [DIGITS:0]   lower_all;
   logic              all_term;
   logic              carry_q;
   logic              carry_d;

   assign lower_all[0] = 1'b1;
   assign all_term     = lower_all[DIGITS];

   for (genvar i = 0; i < DIGITS; i++) begin : g_digit
      assign lower_all[i+1] = lower_all[i] & at_term[i];
`ifdef UDCOUNT_SAT_EN
      assign step[i] = enable & lower_all[i] & ~all_term;
`else
      assign step[i] = enable & lower_all[i];
`endif

      udcount_digit #(
         .RADIX (RADIX),
         .DW    (DW)
      ) u_digit (
         .clock      (clock),
         .reset      (reset),
         .step_in    (step[i]),
         .ud         (ud),
         .load       (load),
         .load_digit (load_value[i*DW +: DW]),
         .digit      (q[i*DW +: DW]),
         .at_term    (at_term[i])
      );
   end

   // A step from the all-terminal state is a wrap (or a blocked step when saturating).
   assign carry_d = enable & ~load & all_term;

   always_ff @(posedge clock) begin
      if (reset) begin
         carry_q <= 1'b0;
      end else begin
         carry_q <= carry_d;
      end
   end

   assign carry = carry_q;
   assign zero  = (q == '0);

endmodule

// File: tb/tb_udcount_mod.sv
// Directed self-checking bench for udcount_mod (2-digit BCD and 1-digit hex).
// Expectations follow the build: wrap by default, saturate with UDCOUNT_SAT_EN.
module tb_udcount_mod;

`ifdef UDCOUNT_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic       clock = 1'b0;
   logic       reset;
   logic       enable;
   logic       ud;
   logic       load;
   logic [7:0] load_value;
   logic [7:0] q;
   logic       carry;
   logic       zero;
   logic [3:0] load_value1;
   logic [3:0] q1;
   logic       carry1;
   logic       zero1;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   udcount_mod #(.DIGITS(2), .RADIX(10), .DW(4)) dut (
      .clock      (clock),
      .reset      (reset),
      .enable     (enable),
      .ud         (ud),
      .load       (load),
      .load_value (load_value),
      .q          (q),
      .carry      (carry),
      .zero       (zero)
   );

   udcount_mod #(.DIGITS(1), .RADIX(16), .DW(4)) dut_hex (
      .clock      (clock),
      .reset      (reset),
      .enable     (enable),
      .ud         (ud),
      .load       (load),
      .load_value (load_value1),
      .q          (q1),
      .carry      (carry1),
      .zero       (zero1)
   );

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_load(input logic [7:0] v);
      load = 1'b1; enable = 1'b0; load_value = v;
      tick();
      load = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; enable = 1'b1; load = 1'b1; ud = 1'b0;
      load_value = 8'h42; load_value1 = 4'h7;
      tick();
      checks++;
      if (q !== 8'h00 || carry !== 1'b0 || zero !== 1'b1) begin
         errors++;
         $display("FAIL reset: q=%h c=%b z=%b want 00/0/1", q, carry, zero);
      end
      checks++;
      if (q1 !== 4'h0 || carry1 !== 1'b0 || zero1 !== 1'b1) begin
         errors++;
         $display("FAIL reset_hex: q=%h c=%b z=%b want 0/0/1", q1, carry1, zero1);
      end
      reset = 1'b0; load = 1'b0; enable = 1'b0;
   endtask

   task automatic test_up_wrap();
      logic [7:0] eq [3] = '{8'h99, SAT ? 8'h99 : 8'h00, SAT ? 8'h99 : 8'h01};
      logic       ec [3] = '{1'b0, 1'b1, SAT};
      do_load(8'h98);
      ud = 1'b0; enable = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (q !== eq[i] || carry !== ec[i]) begin
            errors++;
            $display("FAIL up_wrap[%0d]: q=%h c=%b want %h/%b", i, q, carry, eq[i], ec[i]);
         end
      end
      do_load(8'h19);
      enable = 1'b1;
      tick();
      checks++;
      if (q !== 8'h20 || carry !== 1'b0) begin
         errors++;
         $display("FAIL up_cascade: q=%h c=%b want 20/0", q, carry);
      end
      enable = 1'b0;
   endtask

   task automatic test_down_wrap();
      logic [7:0] eq [2] = '{SAT ? 8'h00 : 8'h99, SAT ? 8'h00 : 8'h98};
      logic       ec [2] = '{1'b1, SAT};
      do_load(8'h00);
      checks++;
      if (zero !== 1'b1) begin
         errors++;
         $display("FAIL down_zero0: z=%b want 1", zero);
      end
      ud = 1'b1; enable = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++;
         if (q !== eq[i] || carry !== ec[i] || zero !== (eq[i] == 8'h00)) begin
            errors++;
            $display("FAIL down_wrap[%0d]: q=%h c=%b z=%b want %h/%b", i, q, carry, zero, eq[i], ec[i]);
         end
      end
      do_load(8'h30);
      enable = 1'b1;
      tick();
      checks++;
      if (q !== 8'h29 || carry !== 1'b0) begin
         errors++;
         $display("FAIL down_borrow: q=%h c=%b want 29/0", q, carry);
      end
      enable = 1'b0;
   endtask

   task automatic test_load_clamp();
      ud = 1'b0; enable = 1'b1; load = 1'b1; load_value = 8'h4F;
      tick();
      checks++;
      if (q !== 8'h49 || carry !== 1'b0) begin
         errors++;
         $display("FAIL load_clamp: q=%h c=%b want 49/0", q, carry);
      end
      load_value = 8'hAB;
      tick();
      checks++;
      if (q !== 8'h99 || carry !== 1'b0) begin
         errors++;
         $display("FAIL load_clamp_hi: q=%h c=%b want 99/0", q, carry);
      end
      load_value = 8'h12;
      tick();
      checks++;
      if (q !== 8'h12 || carry !== 1'b0) begin
         errors++;
         $display("FAIL load_over_wrap: q=%h c=%b want 12/0", q, carry);
      end
      load = 1'b0; enable = 1'b0;
   endtask

   task automatic test_hold_toggle();
      logic [7:0] eq [3];
      logic       ec [3];
      logic       dir [3] = '{1'b0, 1'b1, 1'b0};
      eq = '{SAT ? 8'h99 : 8'h00, SAT ? 8'h98 : 8'h99, SAT ? 8'h99 : 8'h00};
      ec = '{1'b1, !SAT, !SAT};
      do_load(8'h98);
      ud = 1'b0; enable = 1'b1;
      tick();
      enable = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (q !== 8'h99 || carry !== 1'b0) begin
            errors++;
            $display("FAIL hold[%0d]: q=%h c=%b want 99/0", i, q, carry);
         end
      end
      enable = 1'b1;
      for (int i = 0; i < 3; i++) begin
         ud = dir[i];
         tick();
         checks++;
         if (q !== eq[i] || carry !== ec[i]) begin
            errors++;
            $display("FAIL toggle[%0d]: q=%h c=%b want %h/%b", i, q, carry, eq[i], ec[i]);
         end
      end
      enable = 1'b0;
      tick();
      checks++;
      if (carry !== 1'b0 || q !== eq[2]) begin
         errors++;
         $display("FAIL pulse_clear: q=%h c=%b want %h/0", q, carry, eq[2]);
      end
   endtask

   task automatic test_reset_mid();
      do_load(8'h57);
      ud = 1'b0; enable = 1'b1; reset = 1'b1;
      tick();
      checks++;
      if (q !== 8'h00 || carry !== 1'b0 || zero !== 1'b1) begin
         errors++;
         $display("FAIL reset_mid: q=%h c=%b z=%b want 00/0/1", q, carry, zero);
      end
      reset = 1'b0;
      tick();
      checks++;
      if (q !== 8'h01 || carry !== 1'b0 || zero !== 1'b0) begin
         errors++;
         $display("FAIL resume: q=%h c=%b z=%b want 01/0/0", q, carry, zero);
      end
      do_load(8'h98);
      enable = 1'b1;
      tick();
      tick();
      reset = 1'b1;
      tick();
      checks++;
      if (q !== 8'h00 || carry !== 1'b0) begin
         errors++;
         $display("FAIL reset_pulse: q=%h c=%b want 00/0", q, carry);
      end
      reset = 1'b0; enable = 1'b0;
   endtask

   task automatic test_hex_sat();
      logic [3:0] eq [2] = '{SAT ? 4'hF : 4'h0, SAT ? 4'hF : 4'h1};
      logic       ec [2] = '{1'b1, SAT};
      load_value1 = 4'hF;
      do_load(8'h00);
      ud = 1'b0; enable = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++;
         if (q1 !== eq[i] || carry1 !== ec[i]) begin
            errors++;
            $display("FAIL hex_bound[%0d]: q=%h c=%b want %h/%b", i, q1, carry1, eq[i], ec[i]);
         end
      end
      enable = 1'b0;
   endtask

   initial begin
      reset = 1'b0; enable = 1'b0; ud = 1'b0; load = 1'b0;
      load_value = '0; load_value1 = '0;
      #2;
      test_reset();
      test_up_wrap();
      test_down_wrap();
      test_load_clamp();
      test_hold_toggle();
      test_reset_mid();
      test_hex_sat();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
